// File: rtl/alu_pkg.sv
// alu_pkg: opcode enum, fixed instruction field positions and source-usage helper.
// Shared by reg_file, alu_issue_if consumers and alu_issue_stage.
package alu_pkg;
    localparam int REG_NUM = 16;
    localparam int FIELD_W = 4;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS_LSB  = 4;
    localparam int RT_LSB  = 0;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR, OP_ROL, OP_ROR,
        OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_GT, OP_EQ
    } alu_op_e;
    // Shifts and rotates take their amount from elsewhere, so rt is ignored for hazards.
    function automatic logic uses_rt(input logic [3:0] op);
        return !(op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR});
    endfunction
endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_if: instruction in, operand bundle out and writeback port of the issue stage.
// master = upstream/downstream/writeback side, slave = alu_issue_stage.
interface alu_issue_if #(parameter int ALU_SIZE = 16, parameter int INSTR_W = 16);
    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr_in;
    logic                iss_valid;
    logic                iss_ready;
    logic [ALU_SIZE-1:0] alu_in_a;
    logic [ALU_SIZE-1:0] alu_in_b;
    logic [3:0]          alu_sel;
    logic [3:0]          iss_rd;
    logic                wb_en;
    logic [3:0]          wb_addr;
    logic [ALU_SIZE-1:0] wb_data;
    modport master (
        output instr_valid, instr_in, iss_ready, wb_en, wb_addr, wb_data,
        input  instr_ready, iss_valid, alu_in_a, alu_in_b, alu_sel, iss_rd
    );
    modport slave (
        input  instr_valid, instr_in, iss_ready, wb_en, wb_addr, wb_data,
        output instr_ready, iss_valid, alu_in_a, alu_in_b, alu_sel, iss_rd
    );
endinterface

// File: rtl/alu_issue_stage_reg_file.sv
// reg_file: 16-entry register file, two async read ports, one sync write port, R0 reads 0.
// Ports: clk, rst, i_ra/i_rb read addresses, o_da/o_db read data, i_we/i_wa/i_wd write port.
module reg_file
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FIELD_W-1:0] i_ra,
    input  logic [FIELD_W-1:0] i_rb,
    input  logic               i_we,
    input  logic [FIELD_W-1:0] i_wa,
    input  logic [W-1:0]       i_wd,
    output logic [W-1:0]       o_da,
    output logic [W-1:0]       o_db
);
    logic [W-1:0] r_regs [REG_NUM];
    always_ff @(posedge clk) begin
        if (rst) r_regs <= '{default: '0};
        else if (i_we && i_wa != '0) r_regs[i_wa] <= i_wd;
    end
    assign o_da = (i_ra == '0) ? '0 : r_regs[i_ra];
    assign o_db = (i_rb == '0) ? '0 : r_regs[i_rb];
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes instructions, reads operands, stalls on RAW/WAW via busy bits.
// Ports: clk, rst (sync, active-high), bus (alu_issue_if.slave: instr, bundle, writeback).
// Optional ALU_ISSUE_WB_BYPASS_EN forwards same-cycle writeback data to sources and rd check.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int ALU_SIZE = 16,
    parameter int INSTR_W  = 16
) (
    input logic        clk,
    input logic        rst,
    alu_issue_if.slave bus
);
    logic [INSTR_W-1:0]  w_instr;
    logic [3:0]          w_op, w_rd, w_rs, w_rt;
    logic [ALU_SIZE-1:0] w_rf_a, w_rf_b, w_a, w_b;
    logic                w_wb_hit, w_byp_a, w_byp_b, w_byp_d;
    logic                w_hazard, w_ready, w_accept;
    logic [REG_NUM-1:0]  r_busy, w_busy_nxt;
    logic                r_iss_valid;
    logic [ALU_SIZE-1:0] r_alu_a, r_alu_b;
    logic [3:0]          r_alu_sel, r_iss_rd;
    assign w_instr = bus.instr_in;
    assign w_op    = w_instr[OP_LSB +: FIELD_W];
    assign w_rd    = w_instr[RD_LSB +: FIELD_W];
    assign w_rs    = w_instr[RS_LSB +: FIELD_W];
    assign w_rt    = w_instr[RT_LSB +: FIELD_W];
    reg_file #(.W(ALU_SIZE)) u_rf (
        .clk  (clk),
        .rst  (rst),
        .i_ra (w_rs),
        .i_rb (w_rt),
        .i_we (bus.wb_en),
        .i_wa (bus.wb_addr),
        .i_wd (bus.wb_data),
        .o_da (w_rf_a),
        .o_db (w_rf_b)
    );
`ifdef ALU_ISSUE_WB_BYPASS_EN
    assign w_wb_hit = bus.wb_en && bus.wb_addr != '0;
`else
    assign w_wb_hit = 1'b0;
`endif
    assign w_byp_a  = w_wb_hit && bus.wb_addr == w_rs;
    assign w_byp_b  = w_wb_hit && bus.wb_addr == w_rt;
    assign w_byp_d  = w_wb_hit && bus.wb_addr == w_rd;
    assign w_a      = w_byp_a ? bus.wb_data : w_rf_a;
    assign w_b      = w_byp_b ? bus.wb_data : w_rf_b;
    assign w_hazard = (r_busy[w_rs] && !w_byp_a)
                   || (uses_rt(w_op) && r_busy[w_rt] && !w_byp_b)
                   || (r_busy[w_rd] && !w_byp_d);
    assign w_ready  = (!r_iss_valid || bus.iss_ready) && !w_hazard;
    assign w_accept = bus.instr_valid && w_ready;
    // Set is applied after clear so a same-cycle issue to the written-back rd stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.wb_en) w_busy_nxt[bus.wb_addr] = 1'b0;
        if (w_accept) w_busy_nxt[w_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            r_iss_valid <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_iss_rd    <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_accept) begin
                r_iss_valid <= 1'b1;
                r_alu_a     <= w_a;
                r_alu_b     <= w_b;
                r_alu_sel   <= w_op;
                r_iss_rd    <= w_rd;
            end else if (bus.iss_ready) begin
                r_iss_valid <= 1'b0;
            end
        end
    end
    assign bus.instr_ready = w_ready;
    assign bus.iss_valid   = r_iss_valid;
    assign bus.alu_in_a    = r_alu_a;
    assign bus.alu_in_b    = r_alu_b;
    assign bus.alu_sel     = r_alu_sel;
    assign bus.iss_rd      = r_iss_rd;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard and vector-table bench for alu_issue_stage.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    alu_issue_if #(.ALU_SIZE(16), .INSTR_W(16)) bus ();
    alu_issue_stage #(.ALU_SIZE(16), .INSTR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    typedef struct {
        logic [15:0] instr;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] wbv;
    } vec_t;
    vec_t        vecs [6];
    logic [39:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wb(input logic [3:0] ad, input logic [15:0] d);
        bus.wb_en   = 1'b1;
        bus.wb_addr = ad;
        bus.wb_data = d;
        step();
        bus.wb_en = 1'b0;
    endtask
    task automatic issue(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b, input string nm);
        bus.instr_valid = 1'b1;
        bus.instr_in    = ins;
        #1;
        chk({nm, "_ready"}, 40'(bus.instr_ready), 40'd1);
        if (bus.instr_ready) exp_q.push_back({a, b, ins[15:12], ins[11:8]});
        step();
        bus.instr_valid = 1'b0;
        chk({nm, "_latency"}, 40'(bus.iss_valid), 40'd1);
    endtask
    task automatic expect_stall(input logic [15:0] ins, input string nm);
        bus.instr_valid = 1'b1;
        bus.instr_in    = ins;
        #1;
        chk(nm, 40'(bus.instr_ready), 40'd0);
        bus.instr_valid = 1'b0;
    endtask
    // Scoreboard: a bundle leaves at the next rising edge whenever valid & ready hold now.
    always @(negedge clk) begin
        if (!rst && bus.iss_valid && bus.iss_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL drain_unexpected got=%h want=none",
                         {bus.alu_in_a, bus.alu_in_b, bus.alu_sel, bus.iss_rd});
            end else begin
                chk("drain", {bus.alu_in_a, bus.alu_in_b, bus.alu_sel, bus.iss_rd}, exp_q.pop_front());
            end
        end
    end
    initial begin
        vecs[0] = '{16'h2A12, 16'h0005, 16'h0003, 16'h00AA};
        vecs[1] = '{16'h3BA1, 16'h00AA, 16'h0005, 16'h1234};
        vecs[2] = '{16'h8CBA, 16'h1234, 16'h00AA, 16'hBEEF};
        vecs[3] = '{16'hFDC0, 16'hBEEF, 16'h0000, 16'h0001};
        vecs[4] = '{16'h7ED3, 16'h0001, 16'h0008, 16'h7777};
        vecs[5] = '{16'hEFEC, 16'h7777, 16'hBEEF, 16'hFFFF};
        bus.instr_valid = 1'b0;
        bus.instr_in    = '0;
        bus.iss_ready   = 1'b1;
        bus.wb_en       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_iss_valid", 40'(bus.iss_valid), 40'd0);
        chk("rst_alu_a", 40'(bus.alu_in_a), 40'd0);
        chk("rst_alu_b", 40'(bus.alu_in_b), 40'd0);
        chk("rst_alu_sel", 40'(bus.alu_sel), 40'd0);
        chk("rst_iss_rd", 40'(bus.iss_rd), 40'd0);
        chk("rst_instr_ready", 40'(bus.instr_ready), 40'd1);
        wb(4'd1, 16'd5);
        wb(4'd2, 16'd3);
        issue(16'h0312, 16'd5, 16'd3, "add");
        chk("add_a", 40'(bus.alu_in_a), 40'd5);
        chk("add_rd", 40'(bus.iss_rd), 40'd3);
        bus.instr_valid = 1'b1;
        bus.instr_in    = 16'h1433;
        repeat (3) begin
            #1;
            chk("raw_stall", 40'(bus.instr_ready), 40'd0);
            step();
        end
        bus.wb_en   = 1'b1;
        bus.wb_addr = 4'd3;
        bus.wb_data = 16'd8;
        #1;
`ifdef ALU_ISSUE_WB_BYPASS_EN
        chk("raw_byp_ready", 40'(bus.instr_ready), 40'd1);
        exp_q.push_back({16'd8, 16'd8, 4'd1, 4'd4});
        step();
        bus.wb_en       = 1'b0;
        bus.instr_valid = 1'b0;
`else
        chk("raw_wb_cycle_ready", 40'(bus.instr_ready), 40'd0);
        step();
        bus.wb_en = 1'b0;
        #1;
        chk("raw_after_wb_ready", 40'(bus.instr_ready), 40'd1);
        exp_q.push_back({16'd8, 16'd8, 4'd1, 4'd4});
        step();
        bus.instr_valid = 1'b0;
`endif
        chk("raw_valid", 40'(bus.iss_valid), 40'd1);
        chk("raw_a", 40'(bus.alu_in_a), 40'd8);
        chk("raw_b", 40'(bus.alu_in_b), 40'd8);
        step();
        bus.iss_ready = 1'b0;
        issue(16'h0512, 16'd5, 16'd3, "bp_first");
        bus.instr_valid = 1'b1;
        bus.instr_in    = 16'h0712;
        repeat (4) begin
            #1;
            chk("bp_valid", 40'(bus.iss_valid), 40'd1);
            chk("bp_hold", {bus.alu_in_a, bus.alu_in_b, bus.alu_sel, bus.iss_rd}, {16'd5, 16'd3, 4'd0, 4'd5});
            chk("bp_ready", 40'(bus.instr_ready), 40'd0);
            step();
        end
        bus.iss_ready = 1'b1;
        #1;
        chk("bp_release_ready", 40'(bus.instr_ready), 40'd1);
        exp_q.push_back({16'd5, 16'd3, 4'd0, 4'd7});
        step();
        bus.instr_valid = 1'b0;
        chk("bp_next_rd", 40'(bus.iss_rd), 40'd7);
        issue(16'h4615, 16'd5, 16'd0, "shl_busy_rt");
        expect_stall(16'h0815, "add_busy_rt_stall");
        expect_stall(16'h0512, "waw_stall");
        issue(16'h0012, 16'd5, 16'd3, "rd0");
        issue(16'h0100, 16'd0, 16'd0, "r0_not_busy");
        wb(4'd0, 16'hFFFF);
        issue(16'h0900, 16'd0, 16'd0, "r0_read");
        chk("r0_alu_a", 40'(bus.alu_in_a), 40'd0);
        wb(4'd1, 16'd5);
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].instr, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            wb(vecs[i].instr[11:8], vecs[i].wbv);
        end
        step();
        bus.iss_ready = 1'b0;
        issue(16'h0312, 16'd5, 16'd3, "pre_rst");
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        bus.iss_ready = 1'b1;
        #1;
        chk("midrst_iss_valid", 40'(bus.iss_valid), 40'd0);
        chk("midrst_instr_ready", 40'(bus.instr_ready), 40'd1);
        chk("midrst_outputs", {bus.alu_in_a, bus.alu_in_b, bus.alu_sel, bus.iss_rd}, 40'd0);
        issue(16'h1433, 16'd0, 16'd0, "post_rst_r3_free");
        wb(4'd3, 16'd8);
        issue(16'h1633, 16'd8, 16'd8, "post_rst_wb");
        repeat (3) step();
        chk("scoreboard_empty", 40'(exp_q.size()), 40'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue stage directly upstream of the MIPS ALU. Accepts 16-bit instruction words through a valid/ready handshake and decodes the opcode into `alu_sel`. Reads two source operands from an internal 16-entry register file and presents a registered operand bundle to the ALU/execute stage. A busy-bit scoreboard stalls issue on RAW and WAW hazards. Results return through a writeback port.

## Interface
- `ALU_SIZE`, 16, operand and register width (≥2).
- `INSTR_W`, 16, instruction width. Fixed format: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `instr_valid`  input  1  upstream instruction valid.
- `instr_ready`  output  1  stage accepts `instr_in` this cycle (combinational).
- `instr_in`  input  INSTR_W  instruction word.
- `iss_valid`  output  1  operand bundle valid.
- `iss_ready`  input  1  downstream accepts bundle.
- `alu_in_a`  output  ALU_SIZE  value of R[rs].
- `alu_in_b`  output  ALU_SIZE  value of R[rt].
- `alu_sel`  output  4  opcode, passed through unchanged.
- `iss_rd`  output  4  destination register tag.
- `wb_en`  input  1  writeback strobe.
- `wb_addr`  input  4  writeback register.
- `wb_data`  input  ALU_SIZE  writeback value.

## Operation
- **Register file and R0**
  - R0 reads 0. Writes to R0 are ignored.
  - A write occurs at the edge where `wb_en` is high and `wb_addr`≠0.
- **Scoreboard**
  - `busy[15:0]` holds one bit per register; `busy[0]` is always 0.
  - Set on accept when rd≠0.
  - Cleared at the edge where `wb_en` is high and `wb_addr` matches.
  - If set and clear hit the same register in the same cycle, set wins.
- **Source usage**
  - rs is used by every opcode.
  - rt is unused by opcodes 0100–0111 (shift/rotate). For those, rt never causes a hazard and `alu_in_b` = R[rt] as read.
- **Hazard.** Asserted when any of these holds:
  - `busy[rs]`;
  - `busy[rt]` and rt is used;
  - `busy[rd]` (WAW).
- **`instr_ready`** = (`!iss_valid` | `iss_ready`) & `!hazard`.
- **Accept.** On `instr_valid & instr_ready`:
  - Load `alu_in_a`, `alu_in_b`, `alu_sel` and `iss_rd` into the output register.
  - Set `iss_valid`.
- **Output hold and drain**
  - While `iss_valid & !iss_ready`, all issue outputs hold stable.
  - On `iss_valid & iss_ready` with no new accept, `iss_valid` clears.
- **Throughput and width**
  - Throughput is one instruction per cycle when there are no hazards.
  - No width conversion: operands are exactly ALU_SIZE. The stage performs no arithmetic.

## Timing
- **Reset values.** After `rst` is sampled high:
  - `iss_valid`=0; `alu_in_a`=0, `alu_in_b`=0, `alu_sel`=0, `iss_rd`=0.
  - All busy bits 0 and all registers 0.
  - `instr_ready`=1 in the first cycle after reset.
- **Latency.** Accept at edge N → bundle visible with `iss_valid`=1 after edge N.
- **Writeback visibility without bypass.** A write at edge N is readable by an accept at edge N+1 or later.
- **Reset mid-operation**
  - The in-flight bundle is dropped and scoreboard state is lost.
  - A writeback arriving after reset still writes the register file; its busy clear is a no-op.
- **Stall.** A hazard blocks accept; `instr_in` must hold, per upstream valid/ready rules. Stalls are unbounded until the matching writeback arrives.

## Configuration
- `ALU_ISSUE_WB_BYPASS_EN` defined:
  - A source matching `wb_addr` while `wb_en` is high (addr≠0) takes `wb_data` directly.
  - That source is not a hazard in that cycle.
  - A busy rd that is being written back in the same cycle is not a WAW hazard; its busy bit stays set by the new issue.
  - Hazard-to-accept latency after writeback is 0 cycles.
- Not defined:
  - Hazards are evaluated on registered busy state only.
  - Accept occurs at the earliest one cycle after the writeback edge.

## Structure
- **Package `alu_pkg`**
  - `alu_op_e` enum covering the 16 opcodes 0000–1111: add, sub, mul, div, shl, shr, rol, ror, and, or, xor, nor, nand, xnor, gt, eq.
  - Instruction field localparams.
  - `uses_rt(op)` function.
  - `REG_NUM`=16.
- **Sub-module `reg_file`**
  - Two asynchronous read ports, one synchronous write port, R0 hardwired to zero.
  - Bypass and scoreboard stay in `alu_issue_stage`.

## Test plan
- **Reset, then one issue.** Write R1=5 and R2=3 via wb. Issue 0x0312 (add r3,r1,r2). Expect, one cycle after accept: `iss_valid`=1, `alu_in_a`=5, `alu_in_b`=3, `alu_sel`=0, `iss_rd`=3.
- **RAW stall.** Issue 0x0312, then 0x1433 (sub r4,r3,r3). Expect `instr_ready`=0 until wb r3=8.
  - With bypass: accept in the wb cycle, `alu_in_a`=8 and `alu_in_b`=8.
  - Without bypass: accept one cycle later.
- **Downstream backpressure.** `iss_ready`=0 for 4 cycles. Expect outputs frozen, `instr_ready`=0 with a bundle held, and no instruction lost or duplicated once `iss_ready`=1.
- **Shift with busy rt.** With R5 busy, issue 0x4615 (shl r6,r1,r5). Expect accept with no stall.
- **R0 handling.** Issue 0x0012 (rd=0). Expect no busy bit set. wb to R0 with 0xFFFF; a subsequent read of R0 gives `alu_in_a`=0.
- **Reset with in-flight work.** Assert `rst` while `iss_valid`=1 and R3 busy. Expect `iss_valid`=0, `busy`=0 and `instr_ready`=1 in the next cycle.
